// File: rtl/regbank_sequencer.sv
// ============================================================================
// Module   : regbank_sequencer
// Summary  : Command-driven sequencer for an 8x16 register bank port pair.
//            Implements MOVE, SWAP, LOAD-IMMEDIATE and CLEAR-ALL.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regbank_sequencer #(
  parameter int                WIDTH     = 16,
  parameter int                IDW       = 3,
  parameter logic [WIDTH-1:0]  CLR_VALUE = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IDW-1:0]   cmd_a,
  input  logic [IDW-1:0]   cmd_b,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             done,
  output logic             busy,
  input  logic [WIDTH-1:0] bank_rOut,
  output logic [WIDTH-1:0] bank_rIn,
  output logic [IDW-1:0]   bank_inId,
  output logic [IDW-1:0]   bank_outId,
  output logic             bank_ldR
);

  localparam logic [1:0]     c_op_move = 2'b00;
  localparam logic [1:0]     c_op_swap = 2'b01;
  localparam logic [1:0]     c_op_ldi  = 2'b10;
  localparam logic [IDW-1:0] c_last_id = '1;
  localparam logic [IDW-1:0] c_id_one  = {{(IDW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MOV_W  = 3'd1,
    S_LDI_W  = 3'd2,
    S_SWP_RD = 3'd3,
    S_SWP_W1 = 3'd4,
    S_SWP_W2 = 3'd5,
    S_CLR_W  = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDW-1:0]   r_a;
  logic [IDW-1:0]   r_b;
  logic [WIDTH-1:0] r_imm;
  logic [WIDTH-1:0] r_tmp;
  logic [IDW-1:0]   r_cnt;

  logic             w_accept;
  logic             w_clr_last;
  logic             w_ldR;
  logic             w_done;
  logic [WIDTH-1:0] w_rIn;
  logic [IDW-1:0]   w_inId;
  logic [IDW-1:0]   w_outId;

  assign cmd_ready  = (r_state == S_IDLE) && !reset;
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_clr_last = (r_cnt == c_last_id);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_imm   <= '0;
      r_tmp   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a   <= cmd_a;
        r_b   <= cmd_b;
        r_imm <= cmd_imm;
      end
      // Snapshot of R[a] so the second SWAP write can restore it after R[a] is overwritten
      if (r_state == S_SWP_RD) begin
        r_tmp <= bank_rOut;
      end
      if (r_state == S_CLR_W) begin
        r_cnt <= w_clr_last ? '0 : r_cnt + c_id_one;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            c_op_move: w_next = S_MOV_W;
            c_op_swap: w_next = S_SWP_RD;
            c_op_ldi:  w_next = S_LDI_W;
            default:   w_next = S_CLR_W;
          endcase
        end
      end
      S_MOV_W:  w_next = S_IDLE;
      S_LDI_W:  w_next = S_IDLE;
      S_SWP_RD: w_next = S_SWP_W1;
      S_SWP_W1: w_next = S_SWP_W2;
      S_SWP_W2: w_next = S_IDLE;
      S_CLR_W:  w_next = w_clr_last ? S_IDLE : S_CLR_W;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ldR   = 1'b0;
    w_done  = 1'b0;
    w_rIn   = '0;
    w_inId  = '0;
    w_outId = '0;
    case (r_state)
      S_MOV_W: begin
        w_outId = r_b;
        w_inId  = r_a;
        w_rIn   = bank_rOut;
        w_ldR   = 1'b1;
        w_done  = 1'b1;
      end
      S_LDI_W: begin
        w_inId  = r_a;
        w_rIn   = r_imm;
        w_ldR   = 1'b1;
        w_done  = 1'b1;
      end
      S_SWP_RD: begin
        w_outId = r_a;
      end
      S_SWP_W1: begin
        w_outId = r_b;
        w_inId  = r_a;
        w_rIn   = bank_rOut;
        w_ldR   = 1'b1;
      end
      S_SWP_W2: begin
        w_inId  = r_b;
        w_rIn   = r_tmp;
        w_ldR   = 1'b1;
        w_done  = 1'b1;
      end
      S_CLR_W: begin
        w_inId  = r_cnt;
        w_rIn   = CLR_VALUE;
        w_ldR   = 1'b1;
        w_done  = w_clr_last;
      end
      default: begin
        w_ldR   = 1'b0;
      end
    endcase
  end

  // Reset masks outputs in its own cycle so an aborted command cannot land one more write
  assign bank_ldR   = w_ldR && !reset;
  assign done       = w_done && !reset;
  assign busy       = (r_state != S_IDLE) && !reset;
  assign bank_rIn   = reset ? '0 : w_rIn;
  assign bank_inId  = reset ? '0 : w_inId;
  assign bank_outId = reset ? '0 : w_outId;

endmodule

`default_nettype wire

// File: tb/tb_regbank_sequencer.sv
// ============================================================================
// Module   : tb_regbank_sequencer
// Summary  : Scoreboard bench for regbank_sequencer with a behavioural bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regbank_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_a;
  logic [2:0]  cmd_b;
  logic [15:0] cmd_imm;
  logic        done;
  logic        busy;
  logic [15:0] bank_rOut;
  logic [15:0] bank_rIn;
  logic [2:0]  bank_inId;
  logic [2:0]  bank_outId;
  logic        bank_ldR;

  always #5 clk = ~clk;

  regbank_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_imm    (cmd_imm),
    .done       (done),
    .busy       (busy),
    .bank_rOut  (bank_rOut),
    .bank_rIn   (bank_rIn),
    .bank_inId  (bank_inId),
    .bank_outId (bank_outId),
    .bank_ldR   (bank_ldR)
  );

  // Behavioural 8x16 bank: combinational read, clocked write
  logic [15:0] mem  [8];
  logic [15:0] refm [8];
  assign bank_rOut = mem[bank_outId];
  always @(posedge clk) if (bank_ldR) mem[bank_inId] <= bank_rIn;

  typedef struct packed {
    logic [2:0]  id;
    logic [15:0] data;
    logic        done;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_vec = 0;
  int  n_err = 0;
  int  clr_limit = 8;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bank_ldR === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got id %0d data %h, required no write", bank_inId, bank_rIn);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_id",   {29'd0, bank_inId}, {29'd0, mon_e.id});
        chk("wr_data", {16'd0, bank_rIn},  {16'd0, mon_e.data});
        chk("wr_done", {31'd0, done},      {31'd0, mon_e.done});
      end
    end else if (done !== 1'b0) begin
      chk("done_without_ldR", {31'd0, done}, 32'd0);
    end
  end

  // Reference model: predicts the write stream and the resulting bank contents
  task automatic push_expected(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                               input logic [15:0] imm);
    logic [15:0] va, vb;
    case (op)
      2'b00: begin
        exp_q.push_back('{id: a, data: refm[b], done: 1'b1});
        refm[a] = refm[b];
      end
      2'b01: begin
        va = refm[a];
        vb = refm[b];
        exp_q.push_back('{id: a, data: vb, done: 1'b0});
        exp_q.push_back('{id: b, data: va, done: 1'b1});
        refm[a] = vb;
        refm[b] = va;
      end
      2'b10: begin
        exp_q.push_back('{id: a, data: imm, done: 1'b1});
        refm[a] = imm;
      end
      default: begin
        for (int i = 0; i < clr_limit; i++) begin
          exp_q.push_back('{id: 3'(i), data: 16'h0000, done: (i == 7)});
          refm[i] = 16'h0000;
        end
      end
    endcase
  endtask

  // Called at a negedge; returns at the negedge of the first busy cycle
  task automatic issue(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                       input logic [15:0] imm);
    int k = 0;
    while (cmd_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready_before_issue", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_imm   = imm;
    push_expected(op, a, b, imm);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_a     = 3'($urandom);
    cmd_b     = 3'($urandom);
    cmd_imm   = 16'($urandom);
  endtask

  task automatic wait_done(input string name, input int exp_lat, input logic [31:0] exp_pat);
    int          lat   = 1;
    int          nbusy = 0;
    logic [31:0] pat   = '0;
    forever begin
      if (busy === 1'b1) nbusy++;
      pat[lat-1] = bank_ldR;
      if (done === 1'b1 || lat >= 30) break;
      lat++;
      @(negedge clk);
    end
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_busy_cycles"}, nbusy, exp_lat);
    chk({name, "_ldR_pattern"}, pat, exp_pat);
    @(negedge clk);
    chk({name, "_ready_after_done"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < 8; i++) chk({name, "_reg"}, {16'd0, mem[i]}, {16'd0, refm[i]});
  endtask

  logic [1:0]  h_op  [4] = '{2'b10, 2'b00, 2'b01, 2'b10};
  logic [2:0]  h_a   [4] = '{3'd4, 3'd7, 3'd0, 3'd0};
  logic [2:0]  h_b   [4] = '{3'd1, 3'd4, 3'd7, 3'd3};
  logic [15:0] h_imm [4] = '{16'h1234, 16'hFFFF, 16'h0F0F, 16'hBEEF};
  int          h_lat [4] = '{1, 1, 3, 1};

  initial begin
    int idx, cc, guard;
    int acc [4];
    for (int i = 0; i < 8; i++) begin
      mem[i]  = 16'h0000;
      refm[i] = 16'h0000;
    end
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_imm = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready",  {31'd0, cmd_ready}, 32'd0);
    chk("rst_done",   {31'd0, done},      32'd0);
    chk("rst_busy",   {31'd0, busy},      32'd0);
    chk("rst_ldR",    {31'd0, bank_ldR},  32'd0);
    chk("rst_ids",    {26'd0, bank_inId, bank_outId}, 32'd0);
    chk("rst_rIn",    {16'd0, bank_rIn},  32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
    chk("idle_busy",  {31'd0, busy},      32'd0);

    issue(2'b10, 3'd3, 3'd0, 16'hBEEF);  wait_done("ldi", 1, 32'b1);
    issue(2'b00, 3'd5, 3'd3, 16'h0000);  wait_done("move", 1, 32'b1);
    check_regs("ldi_move");

    issue(2'b10, 3'd1, 3'd0, 16'h1111);  wait_done("pre1", 1, 32'b1);
    issue(2'b10, 3'd6, 3'd0, 16'h6666);  wait_done("pre6", 1, 32'b1);
    issue(2'b01, 3'd1, 3'd6, 16'h0000);  wait_done("swap", 3, 32'b110);
    check_regs("swap");

    issue(2'b10, 3'd2, 3'd0, 16'hA5A5);  wait_done("pre2", 1, 32'b1);
    issue(2'b01, 3'd2, 3'd2, 16'h0000);  wait_done("swap_same", 3, 32'b110);
    issue(2'b00, 3'd2, 3'd2, 16'h0000);  wait_done("move_same", 1, 32'b1);
    check_regs("same_id");

    for (int i = 0; i < 8; i++) begin
      issue(2'b10, 3'(i), 3'd0, 16'h1001 + 16'(i * 16'h0111));
      wait_done("fill", 1, 32'b1);
    end
    issue(2'b11, 3'd0, 3'd0, 16'h0000);  wait_done("clear", 8, 32'hFF);
    check_regs("clear");

    for (int i = 0; i < 8; i++) begin
      issue(2'b10, 3'(i), 3'd0, 16'h2002 + 16'(i * 16'h0101));
      wait_done("refill", 1, 32'b1);
    end
    clr_limit = 3;
    issue(2'b11, 3'd0, 3'd0, 16'h0000);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_ldR",   {31'd0, bank_ldR},  32'd0);
    chk("abort_done",  {31'd0, done},      32'd0);
    chk("abort_ready", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", {31'd0, cmd_ready}, 32'd1);
    chk("abort_busy_after",  {31'd0, busy},      32'd0);
    clr_limit = 8;
    check_regs("abort");

    idx = 0; cc = 0; guard = 0;
    cmd_valid = 1'b1;
    while (idx < 4 && guard < 100) begin
      if (cmd_ready === 1'b1) begin
        cmd_op = h_op[idx]; cmd_a = h_a[idx]; cmd_b = h_b[idx]; cmd_imm = h_imm[idx];
        push_expected(h_op[idx], h_a[idx], h_b[idx], h_imm[idx]);
        acc[idx] = cc;
        idx++;
      end else begin
        cmd_op = 2'($urandom); cmd_a = 3'($urandom); cmd_b = 3'($urandom); cmd_imm = 16'($urandom);
      end
      @(negedge clk);
      cc++;
      guard++;
    end
    chk("hold_accepted", idx, 4);
    for (int i = 0; i < 3; i++) chk("hold_spacing", acc[i+1] - acc[i], h_lat[i] + 1);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    check_regs("hold");
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/regbank_sequencer.md
Name: regbank_sequencer

Overview:
- Command-driven initiator for the 8x16 register bank write/read port pair (rIn/inId/ldR write side, outId/rOut read side).
- Turns single-word commands from the control unit into timed sequences of bank read selects and load pulses: MOVE, SWAP, LOAD-IMMEDIATE and CLEAR-ALL.
- Sits between the stack-CPU control FSM and the bank. It is the only driver of the bank's select and load lines.

Parameters:
- WIDTH, 16, data width of bank words and immediate.
- IDW, 3, register-id width (bank depth 2**IDW = 8).
- CLR_VALUE, 16'h0000, word written to every register by CLEAR-ALL.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command this cycle.
- cmd_op  in  2  00 MOVE a<-b, 01 SWAP a<->b, 10 LDI a<-imm, 11 CLEAR-ALL.
- cmd_a  in  IDW  destination / first register id.
- cmd_b  in  IDW  source / second register id.
- cmd_imm  in  WIDTH  immediate for LDI.
- done  out  1  one-cycle pulse in the cycle of a command's final bank write.
- busy  out  1  command in progress (state != IDLE).
- bank_rOut  in  WIDTH  bank read data; combinational in bank_outId.
- bank_rIn  out  WIDTH  bank write data.
- bank_inId  out  IDW  bank write select.
- bank_outId  out  IDW  bank read select.
- bank_ldR  out  1  bank load enable.

Behaviour:
- Reset:
  - reset is synchronous and active-high. On reset, state<=IDLE and the counter and temp registers clear.
  - While reset is high and in the first IDLE cycle: cmd_ready=0 during reset; done=0, busy=0, bank_ldR=0, bank_inId=0, bank_outId=0, bank_rIn=0.
- Handshake:
  - cmd_ready=1 only in IDLE (not under reset). A command is accepted on a clk edge where cmd_valid&&cmd_ready.
  - On acceptance, op/a/b/imm are latched. The inputs are don't-care afterwards.
  - No queueing. cmd_ready returns to 1 the cycle after done.
- Output timing: bank_* and done/busy are decoded from registered state and latched fields only. There is no combinational path from cmd_* to outputs.
  - The one exception is bank_rIn, which equals bank_rOut in read-through write states.
  - In states not listed below, bank_ldR=0 and selects/data are 0.
- States (T = acceptance edge; cycle T+1 is the first non-IDLE cycle):
  - MOV_W: outId=b, inId=a, rIn=bank_rOut, ldR=1, done=1 -> IDLE. Latency 1 cycle.
  - LDI_W: inId=a, rIn=imm, ldR=1, done=1 -> IDLE. Latency 1 cycle.
  - SWP_RD: outId=a, ldR=0; tmp<=bank_rOut at end of cycle -> SWP_W1.
  - SWP_W1: outId=b, inId=a, rIn=bank_rOut, ldR=1 -> SWP_W2.
  - SWP_W2: inId=b, rIn=tmp, ldR=1, done=1 -> IDLE. SWAP latency 3 cycles.
  - CLR_W: inId=cnt, rIn=CLR_VALUE, ldR=1. cnt increments 0..7; at cnt==7, done=1 -> IDLE and cnt<=0. CLEAR-ALL latency 8 cycles, 8 ldR pulses, ids 0..7 in ascending order.
- Boundary cases:
  - MOVE a==b: writes the register with its own value; contents unchanged.
  - SWAP a==b: 3-cycle sequence runs normally; contents unchanged.
  - cmd_valid held high: next command is accepted on the edge after done. Minimum spacing is latency+1 cycles.
  - reset mid-command: abort immediately to IDLE with ldR=0 from the reset cycle onward. Writes already performed persist. No done pulse for the aborted command.
  - cmd_op is fully decoded; there is no illegal opcode.
  - cnt is IDW bits wide and wraps only through the done path.
- Invariants:
  - Exactly one ldR pulse per write cycle.
  - inId and rIn are stable throughout any cycle where ldR=1.
  - done asserts only with ldR=1.

Test Plan:
- After reset, run LDI a=3 imm=16'hBEEF, then MOVE a=5 b=3. Required: each command gives one ldR pulse and done one cycle after acceptance; final R5=R3=16'hBEEF; cmd_ready back high 2 cycles after each acceptance.
- Preload R1=16'h1111, R6=16'h6666, then SWAP a=1 b=6. Required: ldR low in cycle 1, high in cycles 2–3; R1=16'h6666, R6=16'h1111; done in cycle 3 only.
- Preload R2=16'hA5A5, then SWAP a=2 b=2 and MOVE a=2 b=2. Required: R2 stays 16'hA5A5; latencies 3 and 1.
- Load all 8 registers with nonzero values, then CLEAR-ALL. Required: 8 consecutive ldR pulses with inId 0,1,…,7; all registers 16'h0000; done on the 8th cycle; busy high for exactly 8 cycles.
- Start CLEAR-ALL and assert reset at cycle 4 for 1 cycle. Required: ldR=0 from the reset cycle; R0–R2 cleared, R3–R7 unchanged; no done pulse; cmd_ready=1 the cycle after reset drops.
- Hold cmd_valid high with changing cmd_* during busy. Required: no command is accepted until IDLE; latched fields are not corrupted (checked against a reference model).
